id_operand_fetch: RTL
=====================

# id_operand_fetch

Decode-stage operand fetch unit for the cqu_mips five-stage pipeline. It reads the architectural register file on behalf of the instruction leaving decode, and bypasses the value being written back in the same cycle. It tracks outstanding writes in a per-register scoreboard and stalls decode until every source operand is committed. It is the read side paired with the writeback stage: writeback drives its write port, and this block consumes the written values.

## Interface
- No parameters; data width 32, 32 registers, scoreboard counters 2 bits.
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears register file, scoreboard, output register
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  instruction accepted this cycle when in_valid && in_ready
- in_rs  input  5  source register A
- in_rt  input  5  source register B
- in_rd  input  5  destination register
- in_reg_write  input  1  instruction will write in_rd
- out_valid  output  1  execute-side operand register holds an instruction
- out_ready  input  1  execute accepts the held instruction
- out_rs_data  output  32  operand A value
- out_rt_data  output  32  operand B value
- out_rd  output  5  forwarded destination
- out_reg_write  output  1  forwarded write enable, forced 0 when in_rd == 0
- wb_reg_write  input  1  writeback commits this cycle
- wb_rd  input  5  writeback destination
- wb_data  input  32  writeback value (already muxed mem/ALU)

## Operation
- Storage: 32 x 32 register file. Register 0 always reads 0, and writes to it are discarded. Write when wb_reg_write && wb_rd != 0.
- Bypass: a source equal to wb_rd (nonzero) with wb_reg_write high reads wb_data in the same cycle. Otherwise it reads stored value.
- Scoreboard: cnt[r] is 2-bit, r = 1..31. cnt[0] is permanently 0.
  - Issue of a writing instruction (accept && in_reg_write && in_rd != 0) increments cnt[in_rd].
  - Writeback of a nonzero wb_rd decrements cnt[wb_rd]. A writeback to a register with cnt 0 leaves it at 0; no underflow.
  - Issue and writeback to the same register in one cycle leave the count unchanged.
- Source busy: cnt[s] != 0, excluding the case where wb_reg_write && wb_rd == s && cnt[s] == 1. In that case the value is taken from the bypass.
- Stall conditions (in_ready = 0):
  - rs busy;
  - rt busy;
  - in_reg_write && in_rd != 0 && cnt[in_rd] == 3 && no same-cycle decrement of in_rd;
  - output register full and not draining (out_valid && !out_ready).
- in_ready is combinational from the inputs and state. It must not depend on in_valid.
- Output register: loads on accept. When out_valid && out_ready && no accept, out_valid clears. Data holds while out_valid && !out_ready.

## Timing
- Latency: an instruction accepted in cycle N appears on the outputs with out_valid = 1 in cycle N+1.
- Throughput: one instruction per cycle when there is no hazard and out_ready is high.
- A write committed in cycle N is visible through the bypass in cycle N. It is visible from storage from cycle N+1.
- A stall released by writeback in cycle N means the instruction is accepted in cycle N, using the bypassed data.
- Reset values: out_valid = 0, out_rs_data = 0, out_rt_data = 0, out_rd = 0, out_reg_write = 0, all cnt = 0, all registers 0.
- in_ready may be 1 in the cycle reset is high, but no acceptance occurs during reset.
- Reset mid-operation discards the held instruction and all pending counts. Writeback inputs during the reset cycle are ignored.
- Simultaneous writeback to rs and rt (rs == rt) delivers wb_data on both outputs.

## Test plan
- Reset, then read $5/$6 without prior writes → out_rs_data = out_rt_data = 0, out_valid is high one cycle after accept.
- Issue instr writing $3 (cnt[3] = 1), then an instr reading $3 → in_ready = 0. Writeback $3 = 0x1234_5678 → accepted that same cycle, out_rs_data = 0x1234_5678 next cycle.
- Three issues writing $7 followed by a fourth → fourth stalls. One writeback of $7 in the same cycle lets it issue, and cnt[7] stays 3.
- Writeback to $0 with 0xFFFF_FFFF, then read $0 → 0. An instruction with in_rd = 0 and in_reg_write = 1 → out_reg_write = 0 and no counter change.
- out_ready held 0 for 3 cycles with valid input → in_ready = 0, outputs stable. Release → next instruction loaded the following cycle.
- Assert reset while cnt[9] = 2 and out_valid = 1 → next cycle out_valid = 0 and a read of $9 issues immediately.

Source files
------------

// File: rtl/id_operand_fetch.sv
// Decode-stage operand fetch: register file with same-cycle writeback bypass,
// per-register pending-write scoreboard and a one-entry output register toward execute.
module id_operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rs_data,
  output logic [31:0] out_rt_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data
);

  logic [31:0] rf_q  [32];
  logic [31:0] rf_d  [32];
  logic [1:0]  cnt_q [32];
  logic [1:0]  cnt_d [32];

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_rs_q, out_rs_d;
  logic [31:0] out_rt_q, out_rt_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_rw_q, out_rw_d;

  logic        wb_en;
  logic        rs_busy, rt_busy, rd_full, out_block;
  logic        accept;
  logic [31:0] rs_val, rt_val;

  // Hazard detection and operand selection.
  always_comb begin
    wb_en  = wb_reg_write && (wb_rd != 5'd0);
    rs_val = (in_rs == 5'd0) ? 32'd0 : ((wb_en && wb_rd == in_rs) ? wb_data : rf_q[in_rs]);
    rt_val = (in_rt == 5'd0) ? 32'd0 : ((wb_en && wb_rd == in_rt) ? wb_data : rf_q[in_rt]);
    // The last pending write landing this cycle is served by the bypass, not a stall.
    rs_busy = (cnt_q[in_rs] != 2'd0) && !(wb_en && wb_rd == in_rs && cnt_q[in_rs] == 2'd1);
    rt_busy = (cnt_q[in_rt] != 2'd0) && !(wb_en && wb_rd == in_rt && cnt_q[in_rt] == 2'd1);
    rd_full = in_reg_write && (in_rd != 5'd0) && (cnt_q[in_rd] == 2'd3)
              && !(wb_en && wb_rd == in_rd);
    out_block = out_valid_q && !out_ready;
    in_ready  = !(rs_busy || rt_busy || rd_full || out_block);
    accept    = in_valid && in_ready && !reset;
  end

  // NOTE: every variable gets a default before any conditional update so no latch is inferred.
  always_comb begin
    rf_d        = rf_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_rs_d    = out_rs_q;
    out_rt_d    = out_rt_q;
    out_rd_d    = out_rd_q;
    out_rw_d    = out_rw_q;

    if (wb_en) rf_d[wb_rd] = wb_data;

    cnt_d[0] = 2'd0;
    for (int r = 1; r < 32; r++) begin
      if (accept && in_reg_write && in_rd == 5'(r) && !(wb_en && wb_rd == 5'(r)))
        cnt_d[r] = cnt_q[r] + 2'd1;
      else if (wb_en && wb_rd == 5'(r) && !(accept && in_reg_write && in_rd == 5'(r))
               && cnt_q[r] != 2'd0)
        cnt_d[r] = cnt_q[r] - 2'd1;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_rs_d    = rs_val;
      out_rt_d    = rt_val;
      out_rd_d    = in_rd;
      out_rw_d    = in_reg_write && (in_rd != 5'd0);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same cycle's values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register file itself is reset here, which costs a reset mux per bit but guarantees zero reads.
      for (int r = 0; r < 32; r++) begin
        rf_q[r]  <= '0;
        cnt_q[r] <= '0;
      end
      out_valid_q <= 1'b0;
      out_rs_q    <= '0;
      out_rt_q    <= '0;
      out_rd_q    <= '0;
      out_rw_q    <= 1'b0;
    end else begin
      rf_q        <= rf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_rs_q    <= out_rs_d;
      out_rt_q    <= out_rt_d;
      out_rd_q    <= out_rd_d;
      out_rw_q    <= out_rw_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_rs_data   = out_rs_q;
  assign out_rt_data   = out_rt_q;
  assign out_rd        = out_rd_q;
  assign out_reg_write = out_rw_q;

endmodule
